// File: rtl/maze_pkg.sv
// Shared codes, FSM state encoding and heading helpers for the wall-follower controller.
package maze_pkg;

    localparam int unsigned CODE_W = 3;

    localparam logic [2:0] ACAO_NONE = 3'b000;
    localparam logic [2:0] ACAO_N    = 3'b001;
    localparam logic [2:0] ACAO_W    = 3'b010;
    localparam logic [2:0] ACAO_S    = 3'b011;
    localparam logic [2:0] ACAO_E    = 3'b100;

    localparam logic [2:0] ORI_N = 3'b001;
    localparam logic [2:0] ORI_W = 3'b010;
    localparam logic [2:0] ORI_E = 3'b011;
    localparam logic [2:0] ORI_S = 3'b100;

    typedef logic [2:0] wf_state_t;

    localparam wf_state_t ST_IDLE    = 3'd0;
    localparam wf_state_t ST_SETTLE  = 3'd1;
    localparam wf_state_t ST_DECIDE  = 3'd2;
    localparam wf_state_t ST_MOVE    = 3'd3;
    localparam wf_state_t ST_DONE    = 3'd4;
    localparam wf_state_t ST_TRAPPED = 3'd5;
    localparam wf_state_t ST_TIMEOUT = 3'd6;

    // N -> W -> S -> E -> N; an illegal code recovers to north
    function automatic logic [2:0] rotate_left(input logic [2:0] h);
        case (h)
            ORI_N:   return ORI_W;
            ORI_W:   return ORI_S;
            ORI_S:   return ORI_E;
            ORI_E:   return ORI_N;
            default: return ORI_N;
        endcase
    endfunction

    function automatic logic [2:0] rotate_right(input logic [2:0] h);
        case (h)
            ORI_N:   return ORI_E;
            ORI_E:   return ORI_S;
            ORI_S:   return ORI_W;
            ORI_W:   return ORI_N;
            default: return ORI_N;
        endcase
    endfunction

    // Heading and move codes differ for east/south, so map explicitly
    function automatic logic [2:0] heading_to_acao(input logic [2:0] h);
        case (h)
            ORI_N:   return ACAO_N;
            ORI_W:   return ACAO_W;
            ORI_S:   return ACAO_S;
            ORI_E:   return ACAO_E;
            default: return ACAO_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wf_pos_tracker.sv
// Tracks the robot grid position and flags arrival at the exit cell.
module wf_pos_tracker
    import maze_pkg::*;
#(
    parameter int unsigned START_ROW = 11,
    parameter int unsigned START_COL = 1,
    parameter int unsigned GOAL_ROW  = 0,
    parameter int unsigned GOAL_COL  = 20
) (
    input  logic       clockc1,
    input  logic       reset,
    input  logic       move_en,
    input  logic [2:0] heading,
    output logic [7:0] pos_row,
    output logic [7:0] pos_col,
    output logic       at_goal_c
);

    logic [7:0] row_nxt_c;
    logic [7:0] col_nxt_c;

    always_comb begin
        row_nxt_c = pos_row;
        col_nxt_c = pos_col;
        case (heading)
            ORI_N:   row_nxt_c = pos_row - 8'd1;
            ORI_S:   row_nxt_c = pos_row + 8'd1;
            ORI_W:   col_nxt_c = pos_col - 8'd1;
            ORI_E:   col_nxt_c = pos_col + 8'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clockc1 or posedge reset) begin
        if (reset) begin
            pos_row <= 8'(START_ROW);
            pos_col <= 8'(START_COL);
        end else if (move_en) begin
            pos_row <= row_nxt_c;
            pos_col <= col_nxt_c;
        end
    end

    assign at_goal_c = (pos_row == 8'(GOAL_ROW)) && (pos_col == 8'(GOAL_COL));

endmodule

// File: rtl/wall_follower_ctrl.sv
// Left-hand wall-follower: settles sensors, decides turn/move, counts actions,
// and stops on goal, trap (four right turns in a row) or action budget.
module wall_follower_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned START_ROW   = 11,
    parameter int unsigned START_COL   = 1,
    parameter int unsigned GOAL_ROW    = 0,
    parameter int unsigned GOAL_COL    = 20,
    parameter int unsigned MAX_ACTIONS = 1000
) (
    input  logic        clockc1,
    input  logic        reset,
    input  logic        start,
    input  logic        head,
    input  logic        left,
    output logic [2:0]  acao,
    output logic [2:0]  orientacao,
    output logic        busy,
    output logic        done,
    output logic        trapped,
    output logic        timeout,
    output logic [7:0]  pos_row,
    output logic [7:0]  pos_col,
    output logic [15:0] action_count
);

    localparam int unsigned RUN_W = 3;

    wf_state_t        state, state_nxt;
    logic [2:0]       acao_nxt, ori_nxt;
    logic [15:0]      count_nxt, count_inc_c;
    logic             turned_left, tl_nxt;
    logic [RUN_W-1:0] right_run, rr_nxt;
    logic             busy_nxt, done_nxt, trapped_nxt, timeout_nxt;
    logic             move_en_c;
    logic             at_goal_c;

    wf_pos_tracker #(
        .START_ROW (START_ROW),
        .START_COL (START_COL),
        .GOAL_ROW  (GOAL_ROW),
        .GOAL_COL  (GOAL_COL)
    ) u_pos (
        .clockc1   (clockc1),
        .reset     (reset),
        .move_en   (move_en_c),
        .heading   (orientacao),
        .pos_row   (pos_row),
        .pos_col   (pos_col),
        .at_goal_c (at_goal_c)
    );

    assign count_inc_c = (action_count == 16'hFFFF) ? action_count : action_count + 16'd1;

    // Next-state and next-output logic; head/left are only looked at in DECIDE
    always_comb begin
        state_nxt = state;
        acao_nxt  = ACAO_NONE;
        ori_nxt   = orientacao;
        count_nxt = action_count;
        tl_nxt    = turned_left;
        rr_nxt    = right_run;
        move_en_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: state_nxt = ST_DECIDE;
            ST_DECIDE: begin
                if (at_goal_c) begin
                    state_nxt = ST_DONE;
                end else if (action_count == 16'(MAX_ACTIONS)) begin
                    state_nxt = ST_TIMEOUT;
                end else if (!left && !turned_left) begin
                    ori_nxt   = rotate_left(orientacao);
                    tl_nxt    = 1'b1;
                    rr_nxt    = '0;
                    count_nxt = count_inc_c;
                    state_nxt = ST_SETTLE;
                end else if (!head) begin
                    acao_nxt  = heading_to_acao(orientacao);
                    move_en_c = 1'b1;
                    tl_nxt    = 1'b0;
                    rr_nxt    = '0;
                    count_nxt = count_inc_c;
                    state_nxt = ST_MOVE;
                end else begin
                    ori_nxt   = rotate_right(orientacao);
                    tl_nxt    = 1'b0;
                    rr_nxt    = right_run + RUN_W'(1);
                    count_nxt = count_inc_c;
                    state_nxt = (right_run == RUN_W'(3)) ? ST_TRAPPED : ST_SETTLE;
                end
            end
            ST_MOVE:    state_nxt = ST_SETTLE;
            ST_DONE:    state_nxt = ST_DONE;
            ST_TRAPPED: state_nxt = ST_TRAPPED;
            ST_TIMEOUT: state_nxt = ST_TIMEOUT;
            default:    state_nxt = ST_IDLE;
        endcase
        busy_nxt    = (state_nxt == ST_SETTLE) || (state_nxt == ST_DECIDE) || (state_nxt == ST_MOVE);
        done_nxt    = (state_nxt == ST_DONE);
        trapped_nxt = (state_nxt == ST_TRAPPED);
        timeout_nxt = (state_nxt == ST_TIMEOUT);
    end

    always_ff @(posedge clockc1 or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            acao         <= ACAO_NONE;
            orientacao   <= ORI_N;
            action_count <= '0;
            turned_left  <= 1'b0;
            right_run    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            trapped      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            acao         <= acao_nxt;
            orientacao   <= ori_nxt;
            action_count <= count_nxt;
            turned_left  <= tl_nxt;
            right_run    <= rr_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            trapped      <= trapped_nxt;
            timeout      <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Directed scenarios for wall_follower_ctrl; expected per-cycle snapshots are queued then compared.
module tb_wall_follower_ctrl;

    typedef struct packed {
        logic [2:0]  acao;
        logic [2:0]  ori;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        trapped;
        logic        timeout;
    } snap_t;

    logic clockc1 = 1'b0;
    logic reset   = 1'b1;
    logic start   = 1'b0;
    logic head    = 1'b0;
    logic left    = 1'b1;

    logic [2:0]  acao_w [3];
    logic [2:0]  ori_w  [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        trap_w [3];
    logic        to_w   [3];
    logic [7:0]  row_w  [3];
    logic [7:0]  col_w  [3];
    logic [15:0] cnt_w  [3];

    int checks = 0;
    int errors = 0;
    snap_t exp_q[$];
    string tag_q[$];

    always #5 clockc1 = ~clockc1;

    // Instance 0: defaults; 1: goal at (9,1); 2: budget of 5 actions
    wall_follower_ctrl u_dut0 (
        .clockc1(clockc1), .reset(reset), .start(start), .head(head), .left(left),
        .acao(acao_w[0]), .orientacao(ori_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .trapped(trap_w[0]), .timeout(to_w[0]), .pos_row(row_w[0]), .pos_col(col_w[0]),
        .action_count(cnt_w[0]));

    wall_follower_ctrl #(.GOAL_ROW(9), .GOAL_COL(1)) u_dut1 (
        .clockc1(clockc1), .reset(reset), .start(start), .head(head), .left(left),
        .acao(acao_w[1]), .orientacao(ori_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .trapped(trap_w[1]), .timeout(to_w[1]), .pos_row(row_w[1]), .pos_col(col_w[1]),
        .action_count(cnt_w[1]));

    wall_follower_ctrl #(.MAX_ACTIONS(5)) u_dut2 (
        .clockc1(clockc1), .reset(reset), .start(start), .head(head), .left(left),
        .acao(acao_w[2]), .orientacao(ori_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .trapped(trap_w[2]), .timeout(to_w[2]), .pos_row(row_w[2]), .pos_col(col_w[2]),
        .action_count(cnt_w[2]));

    function automatic snap_t mk(input logic [2:0] a, input logic [2:0] o, input int r,
                                 input int c, input int n, input logic b, input logic d,
                                 input logic t, input logic x);
        snap_t s;
        s.acao = a; s.ori = o; s.row = 8'(r); s.col = 8'(c); s.cnt = 16'(n);
        s.busy = b; s.done = d; s.trapped = t; s.timeout = x;
        return s;
    endfunction

    function automatic snap_t get_snap(input int which);
        snap_t s;
        s.acao = acao_w[which]; s.ori = ori_w[which]; s.row = row_w[which];
        s.col = col_w[which]; s.cnt = cnt_w[which]; s.busy = busy_w[which];
        s.done = done_w[which]; s.trapped = trap_w[which]; s.timeout = to_w[which];
        return s;
    endfunction

    task automatic push(input string tag, input snap_t s);
        exp_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic check_now(input int which);
        snap_t got, exp;
        string tag;
        got = get_snap(which);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%h required=<queued entry>", got);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s got=%h required=%h", tag, got, exp);
            end
        end
    endtask

    task automatic step_check(input int which);
        @(posedge clockc1);
        #1;
        check_now(which);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        @(posedge clockc1); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clockc1); #1;
        start = 1'b0;
    endtask

    localparam logic [2:0] N = 3'b001, W = 3'b010, E = 3'b011, S = 3'b100;

    initial begin
        // Reset values and straight north run
        head = 1'b0; left = 1'b1;
        do_reset();
        push("reset_state", mk(0, N, 11, 1, 0, 0, 0, 0, 0));
        check_now(0);
        push("settle0", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        pulse_start();
        check_now(0);
        push("decide0", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        push("move_n1", mk(3'b001, N, 10, 1, 1, 1, 0, 0, 0));
        push("settle1", mk(0, N, 10, 1, 1, 1, 0, 0, 0));
        push("decide1", mk(0, N, 10, 1, 1, 1, 0, 0, 0));
        push("move_n2", mk(3'b001, N, 9, 1, 2, 1, 0, 0, 0));
        push("settle2", mk(0, N, 9, 1, 2, 1, 0, 0, 0));
        push("decide2", mk(0, N, 9, 1, 2, 1, 0, 0, 0));
        push("move_n3", mk(3'b001, N, 8, 1, 3, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++) step_check(0);
        // Asynchronous reset in the middle of MOVE
        #2 reset = 1'b1;
        #1;
        push("reset_mid_move", mk(0, N, 11, 1, 0, 0, 0, 0, 0));
        check_now(0);
        @(negedge clockc1);
        reset = 1'b0;
        @(posedge clockc1); #1;
        pulse_start();
        push("resume_decide", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        push("resume_move", mk(3'b001, N, 10, 1, 1, 1, 0, 0, 0));
        step_check(0);
        step_check(0);

        // Left turn then west move
        head = 1'b1; left = 1'b0;
        do_reset();
        pulse_start();
        push("lt_decide", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        step_check(0);
        push("lt_rotated", mk(0, W, 11, 1, 1, 1, 0, 0, 0));
        step_check(0);
        head = 1'b0;
        push("lt_decide2", mk(0, W, 11, 1, 1, 1, 0, 0, 0));
        push("lt_move_w", mk(3'b010, W, 11, 0, 2, 1, 0, 0, 0));
        push("lt_settle", mk(0, W, 11, 0, 2, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) step_check(0);

        // Boxed in: four right turns then trapped
        head = 1'b1; left = 1'b1;
        do_reset();
        pulse_start();
        push("rt_decide0", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        push("rt_east", mk(0, E, 11, 1, 1, 1, 0, 0, 0));
        push("rt_decide1", mk(0, E, 11, 1, 1, 1, 0, 0, 0));
        push("rt_south", mk(0, S, 11, 1, 2, 1, 0, 0, 0));
        push("rt_decide2", mk(0, S, 11, 1, 2, 1, 0, 0, 0));
        push("rt_west", mk(0, W, 11, 1, 3, 1, 0, 0, 0));
        push("rt_decide3", mk(0, W, 11, 1, 3, 1, 0, 0, 0));
        push("rt_trapped", mk(0, N, 11, 1, 4, 0, 0, 1, 0));
        for (int i = 0; i < 8; i++) step_check(0);
        start = 1'b1; head = 1'b0;
        push("trapped_hold", mk(0, N, 11, 1, 4, 0, 0, 1, 0));
        step_check(0);
        start = 1'b0;
        push("trapped_hold2", mk(0, N, 11, 1, 4, 0, 0, 1, 0));
        step_check(0);

        // Goal at (9,1) reached after two moves north
        head = 1'b0; left = 1'b1;
        do_reset();
        pulse_start();
        push("g_decide0", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        push("g_move1", mk(3'b001, N, 10, 1, 1, 1, 0, 0, 0));
        push("g_settle1", mk(0, N, 10, 1, 1, 1, 0, 0, 0));
        push("g_decide1", mk(0, N, 10, 1, 1, 1, 0, 0, 0));
        push("g_move2", mk(3'b001, N, 9, 1, 2, 1, 0, 0, 0));
        push("g_settle2", mk(0, N, 9, 1, 2, 1, 0, 0, 0));
        push("g_decide2", mk(0, N, 9, 1, 2, 1, 0, 0, 0));
        push("g_done", mk(0, N, 9, 1, 2, 0, 1, 0, 0));
        push("g_done_hold", mk(0, N, 9, 1, 2, 0, 1, 0, 0));
        for (int i = 0; i < 9; i++) step_check(1);

        // Budget of five: left-turn/move alternation then timeout
        head = 1'b0; left = 1'b0;
        do_reset();
        pulse_start();
        push("t_decide0", mk(0, N, 11, 1, 0, 1, 0, 0, 0));
        push("t_turn1", mk(0, W, 11, 1, 1, 1, 0, 0, 0));
        push("t_decide1", mk(0, W, 11, 1, 1, 1, 0, 0, 0));
        push("t_move_w", mk(3'b010, W, 11, 0, 2, 1, 0, 0, 0));
        push("t_settle2", mk(0, W, 11, 0, 2, 1, 0, 0, 0));
        push("t_decide2", mk(0, W, 11, 0, 2, 1, 0, 0, 0));
        push("t_turn3", mk(0, S, 11, 0, 3, 1, 0, 0, 0));
        push("t_decide3", mk(0, S, 11, 0, 3, 1, 0, 0, 0));
        push("t_move_s", mk(3'b011, S, 12, 0, 4, 1, 0, 0, 0));
        push("t_settle4", mk(0, S, 12, 0, 4, 1, 0, 0, 0));
        push("t_decide4", mk(0, S, 12, 0, 4, 1, 0, 0, 0));
        push("t_turn5", mk(0, E, 12, 0, 5, 1, 0, 0, 0));
        push("t_decide5", mk(0, E, 12, 0, 5, 1, 0, 0, 0));
        push("t_timeout", mk(0, E, 12, 0, 5, 0, 0, 0, 1));
        push("t_timeout_hold", mk(0, E, 12, 0, 5, 0, 0, 0, 1));
        for (int i = 0; i < 15; i++) step_check(2);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
